coord_decoder: RTL and testbench



---
 rtl/coord_decoder_pkg.sv | 20 ++
 rtl/coord_decoder_if.sv | 24 ++
 rtl/coord_decoder.sv | 97 +++++++++
 tb/tb_coord_decoder.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/coord_decoder_pkg.sv
// Shared constants and types for the linear-index to (row, column) decoder
// and the downstream area stage that consumes its coordinate pairs.
package coord_decoder_pkg;

   localparam int WIDTH   = 600;
   localparam int COORD_W = 11;
   localparam int IDX_W   = 33;
   localparam int K_W     = $clog2(COORD_W);

   localparam logic [IDX_W-1:0] MAX_INDEX = IDX_W'(WIDTH * (2 ** COORD_W) - 1);
   localparam logic [K_W-1:0]   K_LAST    = K_W'(COORD_W - 1);

   typedef logic [1:0]         state_t;
   typedef logic [COORD_W-1:0] coord_t;

   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_DIV  = 2'd1;
   localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/coord_decoder_if.sv
// Valid/ready bundle carrying pixel indices in and coordinate pairs out.
interface coord_decoder_if;
   import coord_decoder_pkg::*;

   logic             in_valid;
   logic             in_ready;
   logic [IDX_W-1:0] in_index;
   logic             out_valid;
   logic             out_ready;
   coord_t           out_x;
   coord_t           out_y;
   logic             out_err;

   modport master (
      output in_valid, in_index, out_ready,
      input  in_ready, out_valid, out_x, out_y, out_err
   );

   modport slave (
      input  in_valid, in_index, out_ready,
      output in_ready, out_valid, out_x, out_y, out_err
   );

endinterface

// File: rtl/coord_decoder.sv
// Linear pixel index -> (index / WIDTH, index % WIDTH) via a fixed-latency
// restoring division that resolves one quotient bit per clock, MSB first.
module coord_decoder
   import coord_decoder_pkg::*;
(
   input  logic           CLOCK_50,
   input  logic           reset,
   coord_decoder_if.slave bus
);

   localparam logic [IDX_W:0] WIDTH_EXT = (IDX_W + 1)'(WIDTH);

   state_t           r_state;
   logic [IDX_W-1:0] r_rem;
   coord_t           r_q;
   logic [K_W-1:0]   r_k;
   logic             r_valid;
   logic             r_err;
   coord_t           r_x;
   coord_t           r_y;

   logic             w_in_ready;
   logic             w_accept;
   logic             w_out_of_range;
   logic [IDX_W:0]   w_shift;
   logic             w_ge;
   logic [IDX_W-1:0] w_rem_next;
   coord_t           w_q_next;

   assign w_in_ready     = (r_state == ST_IDLE) && !reset;
   assign w_accept       = bus.in_valid && w_in_ready;
   assign w_out_of_range = bus.in_index > MAX_INDEX;

   // One extra bit on the shifted divisor keeps the compare from wrapping.
   assign w_shift    = WIDTH_EXT << r_k;
   assign w_ge       = {1'b0, r_rem} >= w_shift;
   assign w_rem_next = w_ge ? (r_rem - w_shift[IDX_W-1:0]) : r_rem;
   assign w_q_next   = r_q | (coord_t'(w_ge) << r_k);

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_valid <= 1'b0;
         r_err   <= 1'b0;
         r_x     <= '0;
         r_y     <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_rem <= bus.in_index;
                  r_q   <= '0;
                  r_k   <= K_LAST;
                  if (w_out_of_range) begin
                     r_err   <= 1'b1;
                     r_x     <= '0;
                     r_y     <= '0;
                     r_state <= ST_DONE;
                  end else begin
                     r_state <= ST_DIV;
                  end
               end
            end
            ST_DIV: begin
               r_rem <= w_rem_next;
               r_q   <= w_q_next;
               if (r_k == '0) begin
                  r_x     <= w_q_next;
                  r_y     <= w_rem_next[COORD_W-1:0];
                  r_valid <= 1'b1;
                  r_state <= ST_DONE;
               end else begin
                  r_k <= r_k - 1'b1;
               end
            end
            ST_DONE: begin
               // An out-of-range point enters DONE one cycle before it is presented.
               if (!r_valid) begin
                  r_valid <= 1'b1;
               end else if (bus.out_ready) begin
                  r_valid <= 1'b0;
                  r_err   <= 1'b0;
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = r_valid;
   assign bus.out_x     = r_x;
   assign bus.out_y     = r_y;
   assign bus.out_err   = r_err;

endmodule

// File: tb/tb_coord_decoder.sv
// Randomised self-checking bench for coord_decoder against a division model.
module tb_coord_decoder;

   logic CLOCK_50;
   logic reset;
   int   total;
   int   bad;

   coord_decoder_if bus ();

   coord_decoder dut (
      .CLOCK_50 (CLOCK_50),
      .reset    (reset),
      .bus      (bus)
   );

   initial CLOCK_50 = 1'b0;
   always #5 CLOCK_50 = ~CLOCK_50;

   // Reference: plain integer division on the grid; anything past the last
   // pixel of a 2048-row grid is an error reported as (0,0).
   function automatic void model(input logic [32:0] idx, output int ex, output int ey,
                                 output logic eerr);
      longint unsigned v;
      v = longint'(idx);
      if (v >= 64'd600 * 64'd2048) begin
         ex = 0; ey = 0; eerr = 1'b1;
      end else begin
         ex = int'(v / 600); ey = int'(v % 600); eerr = 1'b0;
      end
   endfunction

   function automatic logic [32:0] rand_index();
      logic [32:0] v;
      case ($urandom_range(0, 5))
         0:       v = {1'b1, 32'($urandom())};
         1:       v = 33'($urandom_range(1228800, 1300000));
         2:       v = 33'(600 * $urandom_range(0, 2047));
         default: v = 33'($urandom_range(0, 1228799));
      endcase
      return v;
   endfunction

   // Presents one index and waits for its result; consumes it if out_ready=1.
   // Called and returns at #1 after a rising edge; lat = -1 flags a timeout.
   task automatic run_point(input logic [32:0] idx, output int x, output int y,
                            output logic err, output int lat);
      int waitc;
      bus.in_valid = 1'b1;
      bus.in_index = idx;
      waitc = 0;
      while (!bus.in_ready && waitc < 100) begin
         @(posedge CLOCK_50); #1;
         waitc++;
      end
      @(posedge CLOCK_50); #1;
      bus.in_valid = 1'b0;
      lat = 0;
      while (!bus.out_valid && lat < 40) begin
         @(posedge CLOCK_50); #1;
         lat++;
      end
      if (!bus.out_valid || waitc >= 100) lat = -1;
      x   = int'(bus.out_x);
      y   = int'(bus.out_y);
      err = bus.out_err;
      if (bus.out_ready && bus.out_valid) begin
         @(posedge CLOCK_50); #1;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.in_valid = 1'b0; bus.in_index = '0; bus.out_ready = 1'b1;
      repeat (3) @(posedge CLOCK_50);
      #1;
      total++;
      if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b want=0", bus.in_ready); end
      total++;
      if (bus.out_valid !== 1'b0 || bus.out_err !== 1'b0) begin
         bad++; $display("FAIL reset_valid_err got=%b/%b want=0/0", bus.out_valid, bus.out_err);
      end
      total++;
      if (bus.out_x !== '0 || bus.out_y !== '0) begin
         bad++; $display("FAIL reset_xy got=(%0d,%0d) want=(0,0)", bus.out_x, bus.out_y);
      end
      reset = 1'b0;
      #1;
      total++;
      if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL idle_in_ready got=%b want=1", bus.in_ready); end
      @(posedge CLOCK_50); #1;
   endtask

   task automatic test_sequence();
      logic [32:0] idx [4];
      int x, y, lat, ex, ey;
      logic err, eerr;
      idx[0] = 33'd299; idx[1] = 33'd1800; idx[2] = 33'd3399; idx[3] = 33'd3000;
      for (int i = 0; i < 4; i++) begin
         run_point(idx[i], x, y, err, lat);
         model(idx[i], ex, ey, eerr);
         total++;
         if (x !== ex || y !== ey || err !== eerr) begin
            bad++; $display("FAIL seq_result idx=%0d got=(%0d,%0d,%b) want=(%0d,%0d,%b)",
                            idx[i], x, y, err, ex, ey, eerr);
         end
         total++;
         if (lat != 11) begin bad++; $display("FAIL seq_latency idx=%0d got=%0d want=11", idx[i], lat); end
      end
   endtask

   task automatic test_boundaries();
      logic [32:0] idx [4];
      int want_lat [4];
      int x, y, lat, ex, ey;
      logic err, eerr;
      idx[0] = 33'd0;       want_lat[0] = 11;
      idx[1] = 33'd1228799; want_lat[1] = 11;
      idx[2] = 33'd1228800; want_lat[2] = 1;
      idx[3] = '1;          want_lat[3] = 1;
      for (int i = 0; i < 4; i++) begin
         run_point(idx[i], x, y, err, lat);
         model(idx[i], ex, ey, eerr);
         total++;
         if (x !== ex || y !== ey || err !== eerr) begin
            bad++; $display("FAIL bound_result idx=%0d got=(%0d,%0d,%b) want=(%0d,%0d,%b)",
                            idx[i], x, y, err, ex, ey, eerr);
         end
         total++;
         if (lat != want_lat[i]) begin
            bad++; $display("FAIL bound_latency idx=%0d got=%0d want=%0d", idx[i], lat, want_lat[i]);
         end
      end
   endtask

   task automatic test_hold();
      int x, y, lat, ex, ey, n_unstable, n_ready;
      logic err, eerr;
      bus.out_ready = 1'b0;
      run_point(33'd5000, x, y, err, lat);
      model(33'd5000, ex, ey, eerr);
      total++;
      if (x !== ex || y !== ey || err !== eerr || lat != 11) begin
         bad++; $display("FAIL hold_first got=(%0d,%0d,%b) lat=%0d want=(%0d,%0d,%b) lat=11",
                         x, y, err, lat, ex, ey, eerr);
      end
      bus.in_valid = 1'b1;
      bus.in_index = 33'd700;
      n_unstable = 0; n_ready = 0;
      for (int c = 0; c < 20; c++) begin
         @(posedge CLOCK_50); #1;
         if (bus.out_valid !== 1'b1 || int'(bus.out_x) != ex || int'(bus.out_y) != ey) n_unstable++;
         if (bus.in_ready !== 1'b0) n_ready++;
      end
      total++;
      if (n_unstable != 0) begin bad++; $display("FAIL hold_stable got=%0d bad cycles want=0", n_unstable); end
      total++;
      if (n_ready != 0) begin bad++; $display("FAIL hold_in_ready got=%0d high cycles want=0", n_ready); end
      bus.out_ready = 1'b1;
      @(posedge CLOCK_50); #1;
      total++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         bad++; $display("FAIL hold_release got valid=%b ready=%b want valid=0 ready=1",
                         bus.out_valid, bus.in_ready);
      end
      run_point(33'd700, x, y, err, lat);
      total++;
      if (x != 1 || y != 100 || err !== 1'b0 || lat != 11) begin
         bad++; $display("FAIL hold_pending got=(%0d,%0d,%b) lat=%0d want=(1,100,0) lat=11", x, y, err, lat);
      end
   endtask

   task automatic test_reset_abort();
      int x, y, lat, n_spurious;
      logic err;
      bus.in_valid = 1'b1;
      bus.in_index = 33'd1228799;
      @(posedge CLOCK_50); #1;
      bus.in_valid = 1'b0;
      repeat (5) begin @(posedge CLOCK_50); #1; end
      reset = 1'b1;
      @(posedge CLOCK_50); #1;
      reset = 1'b0;
      #1;
      total++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
         bad++; $display("FAIL abort_state got ready=%b valid=%b want ready=1 valid=0",
                         bus.in_ready, bus.out_valid);
      end
      total++;
      if (bus.out_x !== '0 || bus.out_y !== '0 || bus.out_err !== 1'b0) begin
         bad++; $display("FAIL abort_outputs got=(%0d,%0d,%b) want=(0,0,0)", bus.out_x, bus.out_y, bus.out_err);
      end
      n_spurious = 0;
      for (int c = 0; c < 15; c++) begin
         @(posedge CLOCK_50); #1;
         if (bus.out_valid !== 1'b0) n_spurious++;
      end
      total++;
      if (n_spurious != 0) begin bad++; $display("FAIL abort_no_output got=%0d want=0", n_spurious); end
      run_point(33'd600, x, y, err, lat);
      total++;
      if (x != 1 || y != 0 || err !== 1'b0 || lat != 11) begin
         bad++; $display("FAIL abort_next got=(%0d,%0d,%b) lat=%0d want=(1,0,0) lat=11", x, y, err, lat);
      end
   endtask

   task automatic test_random();
      logic [32:0] idx;
      int x, y, lat, ex, ey;
      logic err, eerr;
      for (int i = 0; i < 30; i++) begin
         idx = rand_index();
         run_point(idx, x, y, err, lat);
         model(idx, ex, ey, eerr);
         total++;
         if (x != ex || y != ey || err !== eerr || lat != (eerr ? 1 : 11)) begin
            bad++; $display("FAIL random idx=%0d got=(%0d,%0d,%b) lat=%0d want=(%0d,%0d,%b) lat=%0d",
                            idx, x, y, err, lat, ex, ey, eerr, eerr ? 1 : 11);
         end
      end
   endtask

   task automatic test_back_to_back();
      int exp_x [$];
      int exp_y [$];
      int ex, ey, cyc, n_acc, n_out, last_acc;
      logic eerr, acc;
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_index  = 33'($urandom_range(0, 1228799));
      cyc = 0; n_acc = 0; n_out = 0; last_acc = -1;
      while (n_out < 8 && cyc < 400) begin
         acc = bus.in_valid && bus.in_ready;
         if (bus.out_valid) begin
            total++;
            if (exp_x.size() == 0) begin
               bad++; $display("FAIL b2b_extra got=(%0d,%0d) want=none", bus.out_x, bus.out_y);
            end else begin
               ex = exp_x.pop_front();
               ey = exp_y.pop_front();
               if (int'(bus.out_x) != ex || int'(bus.out_y) != ey || bus.out_err !== 1'b0) begin
                  bad++; $display("FAIL b2b_result got=(%0d,%0d,%b) want=(%0d,%0d,0)",
                                  bus.out_x, bus.out_y, bus.out_err, ex, ey);
               end
            end
            n_out++;
         end
         @(posedge CLOCK_50); #1;
         cyc++;
         if (acc) begin
            model(bus.in_index, ex, ey, eerr);
            exp_x.push_back(ex);
            exp_y.push_back(ey);
            if (last_acc >= 0) begin
               total++;
               if (cyc - last_acc != 13) begin
                  bad++; $display("FAIL b2b_spacing got=%0d want=13", cyc - last_acc);
               end
            end
            last_acc = cyc;
            n_acc++;
            if (n_acc >= 8) bus.in_valid = 1'b0;
            else            bus.in_index = 33'($urandom_range(0, 1228799));
         end
      end
      total++;
      if (n_out != 8) begin bad++; $display("FAIL b2b_timeout got=%0d results want=8", n_out); end
      bus.in_valid = 1'b0;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_sequence();
      test_boundaries();
      test_hold();
      test_reset_abort();
      test_random();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
